// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the memory.
// master: the access controller; slave: the data memory.
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Runs each load/store from EX/MEM over a req/ack bus and stalls the upstream pipeline
// until the access completes. Optional BUSY timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 M_i,
    input  logic [31:0]                DMaddr_i,
    input  logic [31:0]                DMdata_i,
    dmem_access_ctrl_if.master         mem,
    output logic                       stall_o,
    output logic [31:0]                RDdata_o,
    output logic                       misalign_o,
    output logic                       timeout_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        access;
    logic        expire;

    assign access = (M_i != 2'b00);

`ifdef DMEM_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // Expiry is the BUSY cycle whose increment would reach TIMEOUT_CYCLES; ack wins.
    assign expire = (state_q == StBusy) && !mem.mem_ack &&
                    ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    // BUSY-cycle counter, cleared on entry to BUSY.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && access) begin
            cnt_d = 32'd0;
        end else if (state_q == StBusy && !mem.mem_ack) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Sticky timeout flag.
    always_comb begin
        timeout_d = timeout_q;
        if (expire) begin
            timeout_d = 1'b1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; DONE never looks at M_i since EX/MEM still holds the finished access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (access) state_d = StBusy;
            StBusy:  if (mem.mem_ack || expire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus and result register next values.
    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            StIdle: begin
                if (access) begin
                    req_d   = 1'b1;
                    we_d    = M_i[0];  // write wins when both bits are set
                    addr_d  = {DMaddr_i[31:2], 2'b00};
                    wdata_d = DMdata_i;
                    if (DMaddr_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                end else if (expire) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = 32'hDEADBEEF;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bus and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // FSM outputs: stall is combinational so the access is held from its first cycle.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            StIdle:  stall_o = access;
            StBusy:  stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign RDdata_o      = rdata_q;
    assign misalign_o    = misalign_q;

endmodule
